// File: rtl/sync_fifo_pkg.sv
// Shared constants and status payload for the programmable synchronous FIFO.
package sync_fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 8;

  // Snapshot of the FIFO pulses and flags, for monitors and scoreboards
  typedef struct packed {
    logic wr_ack;
    logic overflow;
    logic underflow;
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
  } fifo_status_t;

  // Width needed to hold an occupancy of 0..depth
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Handshake, data and status bundle of the programmable synchronous FIFO.
interface sync_fifo_prog_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
);
  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic [CNT_W-1:0]      af_thresh;
  logic [CNT_W-1:0]      ae_thresh;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CNT_W-1:0]      count;

  // Requester side
  modport master (
    output wr_en, rd_en, data_in, af_thresh, ae_thresh,
    input  data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count
  );

  // FIFO side
  modport slave (
    input  wr_en, rd_en, data_in, af_thresh, ae_thresh,
    output data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count
  );

endinterface

// File: rtl/sync_fifo_ptr.sv
// Modulo-DEPTH wrap counter used for the FIFO read and write pointers.
module sync_fifo_ptr #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // Advance on inc, wrapping from DEPTH-1 back to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == PTR_W'(DEPTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/almost-empty
// thresholds and an occupancy output.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  sync_fifo_prog_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  wr_ack_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full_c;
  logic                  empty_c;
  logic                  wr_acc_c;
  logic                  rd_acc_c;

  // Occupancy flags and accept decisions from the pre-edge state
  always_comb begin
    full_c   = 1'b0;
    empty_c  = 1'b0;
    wr_acc_c = 1'b0;
    rd_acc_c = 1'b0;
    full_c   = (count_q == CNT_W'(FIFO_DEPTH));
    empty_c  = (count_q == '0);
    wr_acc_c = bus.wr_en && (!full_c || bus.rd_en);
    rd_acc_c = bus.rd_en && !empty_c;
  end

  sync_fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc_c),
    .ptr (wr_ptr)
  );

  sync_fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc_c),
    .ptr (rd_ptr)
  );

  // Storage array; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Occupancy: simultaneous accepted read and write leave it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (wr_acc_c && !rd_acc_c) begin
      count_q <= count_q + CNT_W'(1);
    end else if (rd_acc_c && !wr_acc_c) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // One-cycle status pulses reporting the previous cycle's requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ack_q    <= wr_acc_c;
      overflow_q  <= bus.wr_en && !wr_acc_c;
      underflow_q <= bus.rd_en && !rd_acc_c;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head of queue presented directly; zero while empty
  always_comb begin
    bus.data_out = '0;
    if (!empty_c) begin
      bus.data_out = mem[rd_ptr];
    end
  end
`else
  logic [FIFO_WIDTH-1:0] data_q;

  // Registered read data, held across idle and rejected reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (rd_acc_c) begin
      data_q <= mem[rd_ptr];
    end
  end

  assign bus.data_out = data_q;
`endif

  assign bus.count       = count_q;
  assign bus.full        = full_c;
  assign bus.empty       = empty_c;
  assign bus.almostfull  = (count_q >= bus.af_thresh);
  assign bus.almostempty = (count_q <= bus.ae_thresh);
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: an 8-deep and a 5-deep instance receive
// identical stimulus, each compared against a queue-based reference model.
module tb_sync_fifo_prog;
  import sync_fifo_pkg::*;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_prog_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(8)) b8 ();
  sync_fifo_prog_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(5)) b5 ();

  sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
  sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(5)) dut5 (.clk(clk), .rst(rst), .bus(b5.slave));

  typedef struct packed {
    logic         k;
    logic [W-1:0] dout;
    fifo_status_t st;
    logic [3:0]   cnt;
  } exp_t;

  exp_t         sb [$];
  logic [W-1:0] mq [2][$];
  logic [W-1:0] dl [2];
  int           af [2];
  int           ae [2];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s depth%0d: got 0x%0h expected 0x%0h at %0t", name, (k == 0) ? 8 : 5, act, exp, $time);
    end
  endtask

  // Reference: FIFO as a queue; outputs after the edge follow from the accept rules
  task automatic model(input int k, input bit wr, input bit rd, input logic [W-1:0] din);
    int   depth;
    int   sz;
    bit   wa;
    bit   ra;
    exp_t e;
    depth = (k == 0) ? 8 : 5;
    sz    = mq[k].size();
    wa    = wr && ((sz < depth) || rd);
    ra    = rd && (sz > 0);
    if (ra) dl[k] = mq[k].pop_front();
    if (wa) mq[k].push_back(din);
    sz    = mq[k].size();
    e.k   = k[0];
    e.cnt = 4'(sz);
`ifdef SYNC_FIFO_FWFT_EN
    e.dout = (sz > 0) ? mq[k][0] : '0;
`else
    e.dout = dl[k];
`endif
    e.st.wr_ack      = wa;
    e.st.overflow    = wr && !wa;
    e.st.underflow   = rd && !ra;
    e.st.full        = (sz == depth);
    e.st.empty       = (sz == 0);
    e.st.almostfull  = (sz >= af[k]);
    e.st.almostempty = (sz <= ae[k]);
    sb.push_back(e);
  endtask

  task automatic cycle(input bit wr, input bit rd, input logic [W-1:0] din);
    @(negedge clk);
    b8.wr_en = wr; b8.rd_en = rd; b8.data_in = din;
    b8.af_thresh = 4'(af[0]); b8.ae_thresh = 4'(ae[0]);
    b5.wr_en = wr; b5.rd_en = rd; b5.data_in = din;
    b5.af_thresh = 3'(af[1]); b5.ae_thresh = 3'(ae[1]);
    model(0, wr, rd, din);
    model(1, wr, rd, din);
  endtask

  task automatic check_reset_state();
    check("rst_count", 0, 32'(b8.count), 0);
    check("rst_empty", 0, 32'(b8.empty), 1);
    check("rst_full",  0, 32'(b8.full), 0);
    check("rst_ae",    0, 32'(b8.almostempty), 1);
    check("rst_dout",  0, 32'(b8.data_out), 0);
    check("rst_pulse", 0, 32'({b8.wr_ack, b8.overflow, b8.underflow}), 0);
    check("rst_count", 1, 32'(b5.count), 0);
    check("rst_empty", 1, 32'(b5.empty), 1);
    check("rst_ae",    1, 32'(b5.almostempty), 1);
    check("rst_dout",  1, 32'(b5.data_out), 0);
  endtask

  task automatic idle_inputs();
    b8.wr_en = 1'b0; b8.rd_en = 1'b0; b8.data_in = '0;
    b5.wr_en = 1'b0; b5.rd_en = 1'b0; b5.data_in = '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      dl[k] = '0;
    end
  endtask

  // Monitor: compare every expected entry once the DUT has settled after the edge
  initial begin
    exp_t         e;
    logic [W-1:0] ad;
    fifo_status_t as;
    logic [3:0]   ac;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.k == 1'b0) begin
          ad = b8.data_out;
          as = {b8.wr_ack, b8.overflow, b8.underflow, b8.full, b8.empty, b8.almostfull, b8.almostempty};
          ac = 4'(b8.count);
        end else begin
          ad = b5.data_out;
          as = {b5.wr_ack, b5.overflow, b5.underflow, b5.full, b5.empty, b5.almostfull, b5.almostempty};
          ac = 4'(b5.count);
        end
        check("data_out", int'(e.k), 32'(ad), 32'(e.dout));
        check("status",   int'(e.k), 32'(as), 32'(e.st));
        check("count",    int'(e.k), 32'(ac), 32'(e.cnt));
      end
    end
  end

  initial begin
    int pw;
    int pr;
    af[0] = 6; ae[0] = 2; af[1] = 6; ae[1] = 2;
    b8.af_thresh = 4'(af[0]); b8.ae_thresh = 4'(ae[0]);
    b5.af_thresh = 3'(af[1]); b5.ae_thresh = 3'(ae[1]);
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state();

    // Fill to full, then one write too many
    for (int i = 1; i <= 9; i++) cycle(1'b1, 1'b0, W'(i));
    // Drain, then one read too many
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, '0);

    // Steady occupancy of 3 with simultaneous read/write across pointer wrap
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, W'(16'h0100 + i));
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, W'(16'h0200 + i));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0);

    // Pass-through at full, then at empty
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, W'(16'h0010 + i));
    cycle(1'b1, 1'b1, 16'hBEEF);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0);
    cycle(1'b1, 1'b1, 16'h1234);
    cycle(1'b0, 1'b1, '0);

    // Head visibility without reads, then pop to empty
    cycle(1'b1, 1'b0, 16'hA5A5);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, '0);

    // Threshold crossings, then asynchronous reset at count 5
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, W'(16'h0300 + i));
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);
    @(posedge clk);
    #3;
    idle_inputs();
    rst = 1'b1;
    #1;
    check_reset_state();
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic with phases of write-heavy and read-heavy bias
    for (int i = 0; i < 600; i++) begin
      if ((i % 50) == 0) begin
        af[0] = int'($urandom_range(0, 15));
        ae[0] = int'($urandom_range(0, 15));
        af[1] = int'($urandom_range(0, 7));
        ae[1] = int'($urandom_range(0, 7));
      end
      pw = (((i / 50) % 2) == 0) ? 75 : 30;
      pr = 100 - pw;
      cycle(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), W'($urandom));
    end
    cycle(1'b0, 1'b0, '0);

    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
